// File: rtl/imem_responder_if.sv
// Fetch/load bus between the CPU (master) and the instruction memory responder (slave).
interface imem_responder_if;
    logic        start_i;
    logic [31:0] addr_i;
    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        stall_o;

    // Fetch: the master holds start_i/addr_i high and stable while stall_o=1; the word on
    // instr_o is good only in the cycle valid_o=1, and the PC advances on the edge that ends it.
    modport master (
        output start_i, addr_i, wr_en_i, wr_addr_i, wr_data_i,
        input  instr_o, valid_o, stall_o
    );

    modport slave (
        input  start_i, addr_i, wr_en_i, wr_addr_i, wr_data_i,
        output instr_o, valid_o, stall_o
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with fixed multi-cycle fetch latency and a stall output for the PC.
// Optional one-entry hit buffer enabled by defining IMEM_HIT_BUF_EN.
module imem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    imem_responder_if.slave   bus,
    output logic [1:0]        dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   fetch_idx;
    logic [AW-1:0]   load_idx;
    logic            unused_addr_bits;

    assign fetch_idx = bus.addr_i[AW+1:2];
    assign load_idx  = bus.wr_addr_i[AW+1:2];
    assign unused_addr_bits = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0],
                                bus.wr_addr_i[31:AW+2], bus.wr_addr_i[1:0]};

    // Array is never reset so a program load survives a CPU reset.
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i) begin
            mem[load_idx] <= bus.wr_data_i;
        end
    end

`ifdef IMEM_HIT_BUF_EN
    logic            buf_valid;
    logic [AW-1:0]   buf_tag;
    logic [31:0]     buf_data;
    logic            hit;

    // A write in the same cycle vetoes the hit: the buffered copy may be the word being changed.
    assign hit = buf_valid && !bus.wr_en_i && (fetch_idx == buf_tag);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (bus.wr_en_i) begin
            buf_valid <= 1'b0;
        end else if (state_d == DONE) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_d;
            buf_data  <= instr_d;
        end
    end
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    addr_d = fetch_idx;
`ifdef IMEM_HIT_BUF_EN
                    if (hit) begin
                        state_d = DONE;
                        instr_d = buf_data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
`else
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
`endif
                end
            end
            WAIT: begin
                if (!bus.start_i) begin
                    state_d = IDLE;
                end else if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    // Array read sees pre-write contents when a load hits the same edge.
                    state_d = DONE;
                    instr_d = mem[addr_q];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    assign bus.instr_o = instr_q;
    assign bus.valid_o = (state == DONE);
    assign bus.stall_o = bus.start_i && (state != DONE);
    assign dbg_state   = state;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH=256, LATENCY=2); covers IMEM_HIT_BUF_EN builds too.
module tb_imem_responder;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         tests_run;
    int         tests_failed;

    imem_responder_if bus ();

    imem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        step();
        bus.wr_en_i   = 1'b0;
    endtask

    // Issues a fetch from IDLE and measures cycles from the request cycle to valid_o.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input int exp_lat);
        int n;
        n = 0;
        bus.start_i = 1'b1;
        bus.addr_i  = a;
        @(negedge clk);
        while (!bus.valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_data"}, bus.instr_o, exp);
        step();
        bus.start_i = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.start_i   = 1'b0;
        bus.addr_i    = '0;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;

        repeat (2) @(negedge clk);
        check("rst_instr", bus.instr_o, 32'h0);
        check("rst_valid", 32'(bus.valid_o), 32'h0);
        check("rst_stall", 32'(bus.stall_o), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        rst_n = 1'b1;
        step();

        // Basic fetch, cycle by cycle.
        load(32'h10, 32'h8C010004);
        bus.start_i = 1'b1;
        bus.addr_i  = 32'h10;
        @(negedge clk);
        check("c0_stall", 32'(bus.stall_o), 32'h1);
        check("c0_valid", 32'(bus.valid_o), 32'h0);
        step(); @(negedge clk);
        check("c1_stall", 32'(bus.stall_o), 32'h1);
        step(); @(negedge clk);
        check("c2_stall", 32'(bus.stall_o), 32'h1);
        check("c2_valid", 32'(bus.valid_o), 32'h0);
        step(); @(negedge clk);
        check("c3_valid", 32'(bus.valid_o), 32'h1);
        check("c3_instr", bus.instr_o, 32'h8C010004);
        check("c3_stall", 32'(bus.stall_o), 32'h0);
        step();
        bus.start_i = 1'b0;
        @(negedge clk);
        check("c4_valid", 32'(bus.valid_o), 32'h0);
        check("c4_state", 32'(dbg_state), 32'h0);

        // Abort: start_i dropped in cycle 1; the write first clears any buffered copy.
        load(32'h40, 32'hDEADBEEF);
        bus.start_i = 1'b1;
        bus.addr_i  = 32'h10;
        step();
        bus.start_i = 1'b0;
        @(negedge clk);
        check("abort_c1_stall", 32'(bus.stall_o), 32'h0);
        step(); @(negedge clk);
        check("abort_state", 32'(dbg_state), 32'h0);
        check("abort_valid", 32'(bus.valid_o), 32'h0);
        check("abort_instr", bus.instr_o, 32'h8C010004);

        // Address wrap and ignored byte-offset bits.
        load(32'h0, 32'h20020005);
        fetch("wrap", 32'h400, 32'h20020005, 3);
        load(32'h44, 32'h12345678);
        fetch("offset", 32'h13, 32'h8C010004, 3);
        fetch("high_bits", 32'hFFFF_FC40, 32'hDEADBEEF, 3);

        // Write and fetch read of the same word on the cnt==0 edge.
        load(32'h20, 32'h11111111);
        bus.start_i = 1'b1;
        bus.addr_i  = 32'h20;
        step();
        step();
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 32'h20;
        bus.wr_data_i = 32'h22222222;
        step();
        bus.wr_en_i   = 1'b0;
        @(negedge clk);
        check("coll_valid", 32'(bus.valid_o), 32'h1);
        check("coll_instr", bus.instr_o, 32'h11111111);
        step();
        bus.start_i = 1'b0;
        step();
        fetch("after_coll", 32'h20, 32'h22222222, 3);

`ifdef IMEM_HIT_BUF_EN
        fetch("hit", 32'h20, 32'h22222222, 1);
        load(32'h80, 32'h0);
        fetch("miss_after_wr", 32'h20, 32'h22222222, 3);
`else
        fetch("refetch", 32'h20, 32'h22222222, 3);
`endif

        // Reset in the middle of a fetch; array contents survive.
        bus.start_i = 1'b1;
        bus.addr_i  = 32'h10;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(dbg_state), 32'h0);
        check("midrst_instr", bus.instr_o, 32'h0);
        check("midrst_valid", 32'(bus.valid_o), 32'h0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fetch("post_rst", 32'h10, 32'h8C010004, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
